global_ram_readback: RTL and testbench

- Reader counterpart of the global-BRAM load path.
- After a fused-layer run, it fetches a region of global BRAM as 128-bit words at consecutive word addresses and serialises each word into 32-bit beats on a valid/ready stream. The host/DUT dump logic consumes that stream.
- Byte order matches the loader: byte 0 sits in bits [7:0] of word 0.

---
 rtl/readback_pkg.sv | 32 +++
 rtl/readback_word_fifo.sv | 58 +++++
 rtl/global_ram_readback.sv | 158 +++++++++++++++
 tb/tb_global_ram_readback.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/readback_pkg.sv
// Shared definitions for the global-BRAM readback path.
// Holds the bus widths, the BRAM read latency, the controller state
// encoding and the helper that builds the byte mask for the final beat.
package readback_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int OUT_W  = 32;
  localparam int LANES  = DATA_W / OUT_W;
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Byte-enable mask for the last beat of a region of size_bytes bytes.
  // Bytes at or beyond the region end are cleared; a multiple-of-4 size
  // keeps the whole beat.
  function automatic logic [OUT_W-1:0] tail_mask(input logic [31:0] size_bytes);
    logic [OUT_W-1:0] m;
    case (size_bytes[1:0])
      2'd1:    m = 32'h0000_00FF;
      2'd2:    m = 32'h0000_FFFF;
      2'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/readback_word_fifo.sv
// Two-entry word FIFO between the BRAM read port and the beat serialiser.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, wdata       write strobe and word
//   pop               remove head word (ignored when empty)
//   rdata             head word (valid while !empty)
//   full, empty       occupancy flags
//   count             number of stored words (0..2)
// A push and a pop in the same cycle are both honoured; a push into a full
// FIFO is only accepted when the head is popped in the same cycle.
module readback_word_fifo
  import readback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/global_ram_readback.sv
// Reads a region of global BRAM as 128-bit words at consecutive addresses
// and serialises each word into 32-bit beats, lane 0 (bits [31:0]) first.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   begin a readback (sampled only in IDLE)
//   base_addr, size_bytes   first word address, region length in bytes
//   re_global               BRAM read enable (registered)
//   rd_addr_global          BRAM word address (registered)
//   data_in_global          BRAM data, valid RD_LAT cycles after re_global
//   m_data/m_valid/m_ready  output beat stream
//   m_last                  final beat of the region
//   busy                    high from accepted start until done
//   done                    one-cycle completion pulse
//   dbg_state               current controller state
// Stream handshake: a beat transfers on a cycle where m_valid && m_ready.
// Once m_valid is high it stays high, with m_data and m_last unchanged,
// until that transfer happens.
module global_ram_readback
  import readback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       size_bytes,
  output logic              re_global,
  output logic [ADDR_W-1:0] rd_addr_global,
  input  logic [DATA_W-1:0] data_in_global,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [27:0]       last_word_q;   // index of the final word
  logic [29:0]       last_beat_q;   // index of the final beat
  logic [OUT_W-1:0]  mask_q;
  logic [27:0]       issue_idx;
  logic              issue_done;
  logic [29:0]       beat_idx;
  logic [RD_LAT-1:0] rd_pipe;       // one bit per in-flight read

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              fifo_pop;

  logic [2:0]        outstanding;
  logic              can_issue;
  logic [1:0]        lane;
  logic              is_last;
  logic              hs;
  logic [OUT_W-1:0]  lane_data;

  assign dbg_state = state;

  readback_word_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_pipe[RD_LAT-1]),
    .wdata (data_in_global),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit: buffered words plus reads still travelling (the read being
  // presented this cycle included) must stay below the FIFO depth.
  always_comb begin
    outstanding = 3'(fifo_count) + 3'(re_global);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + 3'(rd_pipe[i]);
    end
  end

  assign can_issue = (state == RUN) && !issue_done && (outstanding < 3'd2);

  assign lane      = beat_idx[1:0];
  assign is_last   = (beat_idx == last_beat_q);
  assign lane_data = fifo_head[32'(lane) * OUT_W +: OUT_W];
  assign m_valid   = (state == RUN) && !fifo_empty;
  assign m_last    = m_valid && is_last;
  assign m_data    = m_valid ? (is_last ? (lane_data & mask_q) : lane_data) : '0;
  assign hs        = m_valid && m_ready;
  assign fifo_pop  = hs && ((lane == 2'(LANES - 1)) || is_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      last_word_q    <= '0;
      last_beat_q    <= '0;
      mask_q         <= '0;
      issue_idx      <= '0;
      issue_done     <= 1'b0;
      beat_idx       <= '0;
      rd_pipe        <= '0;
      re_global      <= 1'b0;
      rd_addr_global <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      re_global <= 1'b0;
      done      <= 1'b0;
      rd_pipe   <= RD_LAT'({rd_pipe, re_global});
      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            last_word_q <= 28'((size_bytes - 32'd1) >> 4);
            last_beat_q <= 30'((size_bytes - 32'd1) >> 2);
            mask_q      <= tail_mask(size_bytes);
            issue_idx   <= '0;
            issue_done  <= 1'b0;
            beat_idx    <= '0;
            busy        <= 1'b1;
            if (size_bytes == 32'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            re_global      <= 1'b1;
            rd_addr_global <= base_q + ADDR_W'(issue_idx);
            if (issue_idx == last_word_q) issue_done <= 1'b1;
            else                          issue_idx  <= issue_idx + 28'd1;
          end
          if (hs) begin
            if (is_last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              beat_idx <= beat_idx + 30'd1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_ram_readback.sv
module tb_global_ram_readback;
  import readback_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  size_bytes = '0;
  logic         re_global;
  logic [31:0]  rd_addr_global;
  logic [127:0] data_in_global = '0;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         m_last;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  global_ram_readback dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .size_bytes     (size_bytes),
    .re_global      (re_global),
    .rd_addr_global (rd_addr_global),
    .data_in_global (data_in_global),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];       // {last, data}
  logic [31:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  int issued_n, consumed_n, beat_k, done_cnt;
  bit zero_run = 0;
  bit skip_mon = 0;
  bit last_hs_prev = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  int ready_mode = 0;
  int rc = 0;
  logic [3:0] ready_pat = 4'b1001;   // 1,0,0,1 repeating

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory image: lane k of word a is {a[23:0], 0xA, k}; byte 0 in bits [7:0].
  function automatic logic [31:0] lane_val(input logic [31:0] a, input int k);
    return {a[23:0], 4'hA, 4'(k)};
  endfunction

  // BRAM model, one cycle read latency.
  always @(posedge clk) begin
    if (re_global)
      data_in_global <= {lane_val(rd_addr_global, 3), lane_val(rd_addr_global, 2),
                         lane_val(rd_addr_global, 1), lane_val(rd_addr_global, 0)};
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rc++;
      m_ready = (ready_mode == 0) ? 1'b1 : ready_pat[rc % 4];
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset || skip_mon) begin
      prev_stall   = 0;
      last_hs_prev = 0;
    end else begin
      if (done) begin
        done_cnt++;
        if (!zero_run) chk("done_after_last_beat", 64'(last_hs_prev), 1);
      end
      if (re_global) begin
        issued_n++;
        chk("outstanding_le_2", 64'((issued_n - consumed_n) <= 2), 1);
        chk("read_expected", 64'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) chk("rd_addr", rd_addr_global, exp_addr_q.pop_front());
      end
      if (prev_stall) begin
        chk("stall_valid_held", 64'(m_valid), 1);
        chk("stall_data_held", m_data, prev_data);
        chk("stall_last_held", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("beat", {m_last, m_data}, exp_q.pop_front());
        if ((beat_k % 4 == 3) || m_last) consumed_n++;
        beat_k++;
      end
      last_hs_prev = m_valid && m_ready && m_last;
      prev_stall   = m_valid && !m_ready;
      prev_data    = m_data;
      prev_last    = m_last;
    end
  end

  // ---------------- driver ----------------
  task automatic run_region(input logic [31:0] base, input logic [31:0] size,
                            input int mode, input bit timing, input bit inject);
    int n_beats, n_words, cyc;
    bit got;
    logic [31:0] w, v, mask;
    ready_mode = mode;
    zero_run   = (size == 0);
    issued_n = 0; consumed_n = 0; beat_k = 0; done_cnt = 0;
    n_beats = int'((64'(size) + 3) / 4);
    n_words = int'((64'(size) + 15) / 16);
    mask = (size % 4 == 0) ? 32'hFFFF_FFFF : ((32'h1 << (8 * (size % 4))) - 1);
    for (int j = 0; j < n_beats; j++) begin
      w = base + 32'(j / 4);
      v = lane_val(w, j % 4);
      if (j == n_beats - 1) v = v & mask;
      exp_q.push_back({(j == n_beats - 1), v});
    end
    for (int i = 0; i < n_words; i++) exp_addr_q.push_back(base + 32'(i));

    @(negedge clk);
    start = 1'b1; base_addr = base; size_bytes = size;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (timing) begin
        if (cyc == 1) begin chk("busy_rise", 64'(busy), 1); chk("re_not_yet", 64'(re_global), 0); end
        if (cyc == 2) chk("re_at_t1", 64'(re_global), 1);
        if (cyc == 3) chk("valid_not_yet", 64'(m_valid), 0);
        if (cyc == 4) chk("valid_at_t3", 64'(m_valid), 1);
      end
      if (inject && cyc == 4) begin start = 1'b1; base_addr = 32'h999; size_bytes = 32'd64; end
      if (inject && cyc == 5) begin start = 1'b0; chk("busy_during_run", 64'(busy), 1); end
      if (done) got = 1;
    end
    chk("done_seen", 64'(got), 1);
    if (timing) chk("done_cycle", 64'(cyc), 20);
    if (size == 0) chk("zero_done_quick", 64'(cyc <= 3), 1);
    repeat (4) @(negedge clk);
    chk("done_once", 64'(done_cnt), 1);
    chk("beats_left", 64'(exp_q.size()), 0);
    chk("reads_left", 64'(exp_addr_q.size()), 0);
    chk("busy_idle", 64'(busy), 0);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen_done;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(m_valid), 0);
    chk("reset_re", 64'(re_global), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_region(32'h0,         32'd64, 0, 1, 0);  // full region, latency and throughput
    run_region(32'h100,       32'd20, 0, 0, 1);  // aligned tail, start while busy
    run_region(32'h200,       32'd18, 0, 0, 0);  // unaligned tail
    run_region(32'h40,        32'd64, 1, 0, 0);  // backpressure 1,0,0,1
    run_region(32'h300,       32'd0,  0, 0, 0);  // zero size
    run_region(32'hFFFF_FFFF, 32'd32, 0, 0, 0);  // address wrap

    // Reset in the middle of a drain.
    skip_mon   = 1;
    ready_mode = 1;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h500; size_bytes = 32'd64;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", 64'(m_valid), 0);
    chk("mid_reset_data", m_data, 0);
    chk("mid_reset_last", 64'(m_last), 0);
    chk("mid_reset_re", 64'(re_global), 0);
    chk("mid_reset_addr", rd_addr_global, 0);
    chk("mid_reset_busy", 64'(busy), 0);
    chk("mid_reset_done", 64'(done), 0);
    chk("mid_reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || m_valid || re_global) seen_done = 1;
    end
    chk("quiet_after_reset", 64'(seen_done), 0);
    skip_mon = 0;

    run_region(32'h600, 32'd36, 1, 0, 0);  // recovery after reset, tail of one beat

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
